// File: rtl/sample_loopback_gen_if.sv
// Player/sampler bus between the HPS-side streaming ports and the loopback generator.
interface sample_loopback_gen_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned LED_BITS = 4
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]          mode;
  logic [AW-1:0]       delay;
  logic [WIDTH-1:0]    player_data;
  logic                player_active;
  logic                sampler_active;
  logic [WIDTH-1:0]    sampler_data;
  logic                play_enable;
  logic [15:0]         err_count;
  logic [LED_BITS-1:0] led;

  modport master (
    output mode, delay, player_data, player_active, sampler_active,
    input  sampler_data, play_enable, err_count, led
  );

  modport slave (
    input  mode, delay, player_data, player_active, sampler_active,
    output sampler_data, play_enable, err_count, led
  );
endinterface

// File: rtl/sample_loopback_gen.sv
// Sample source for HPS player/sampler bring-up: delayed loopback, counter, LFSR or zero,
// plus a counter-sequence checker and a heartbeat/error LED.
module sample_loopback_gen #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned LED_BITS = 4,
  parameter int unsigned DIV_BITS = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sample_loopback_gen_if.slave  lb_if
);
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FW   = $clog2(DEPTH + 1);
  localparam int unsigned HB_W = DIV_BITS + LED_BITS;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d, rd_idx;
  logic [FW-1:0]       fill_q, fill_d;
  logic [WIDTH-1:0]    loop_word;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic                lfsr_fb;
  logic [WIDTH-1:0]    sdata_q, sdata_d;
  logic                pen_q, pen_d;
  logic [WIDTH-1:0]    prev_data_q, prev_data_d;
  logic                prev_valid_q, prev_valid_d;
  logic [15:0]         err_q, err_d;
  logic [HB_W-1:0]     hb_q, hb_d;
  logic [LED_BITS-1:0] led_q, led_d;

  // Delay-line storage; fill gating makes reset of the contents unnecessary.
  always_ff @(posedge clk) begin
    if (lb_if.player_active) begin
      mem[wptr_q] <= lb_if.player_data;
    end
  end

  always_comb begin
    wptr_d       = wptr_q;
    fill_d       = fill_q;
    count_d      = count_q;
    lfsr_d       = lfsr_q;
    sdata_d      = '0;
    pen_d        = lb_if.sampler_active;
    prev_data_d  = prev_data_q;
    prev_valid_d = lb_if.player_active;
    err_d        = err_q;
    hb_d         = hb_q + HB_W'(1);

    // Read slot holds the word written D+1 cycles ago; at D=DEPTH-1 it is the slot being overwritten.
    rd_idx    = wptr_q - lb_if.delay - AW'(1);
    loop_word = (fill_q > FW'(lb_if.delay)) ? mem[rd_idx] : '0;
    lfsr_fb   = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];

    if (lb_if.player_active) begin
      wptr_d      = wptr_q + AW'(1);
      fill_d      = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + FW'(1);
      prev_data_d = lb_if.player_data;
    end else begin
      fill_d = '0;
    end

    if (lb_if.sampler_active) begin
      count_d = count_q + WIDTH'(1);
      lfsr_d  = {lfsr_q[30:0], lfsr_fb};
    end

    case (lb_if.mode)
      2'd0:    sdata_d = loop_word;
      2'd1:    sdata_d = count_q;
      2'd2:    sdata_d = WIDTH'(lfsr_q);
      default: sdata_d = '0;
    endcase

    if ((lb_if.mode == 2'd1) && lb_if.player_active && prev_valid_q &&
        (lb_if.player_data != prev_data_q + WIDTH'(1)) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end

    // Computed from next-state values so led always matches the current heartbeat/err_count.
    led_d = (err_d == 16'd0) ? hb_d[HB_W-1 -: LED_BITS] : {LED_BITS{hb_d[DIV_BITS-1]}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q       <= '0;
      fill_q       <= '0;
      count_q      <= '0;
      lfsr_q       <= 32'h0000_0001;
      sdata_q      <= '0;
      pen_q        <= 1'b0;
      prev_data_q  <= '0;
      prev_valid_q <= 1'b0;
      err_q        <= '0;
      hb_q         <= '0;
      led_q        <= '0;
    end else begin
      wptr_q       <= wptr_d;
      fill_q       <= fill_d;
      count_q      <= count_d;
      lfsr_q       <= lfsr_d;
      sdata_q      <= sdata_d;
      pen_q        <= pen_d;
      prev_data_q  <= prev_data_d;
      prev_valid_q <= prev_valid_d;
      err_q        <= err_d;
      hb_q         <= hb_d;
      led_q        <= led_d;
    end
  end

  assign lb_if.sampler_data = sdata_q;
  assign lb_if.play_enable  = pen_q;
  assign lb_if.err_count    = err_q;
  assign lb_if.led          = led_q;
endmodule

// File: tb/tb_sample_loopback_gen.sv
// Directed bench for sample_loopback_gen (WIDTH=8, DEPTH=8, fast heartbeat).
module tb_sample_loopback_gen;
  localparam int unsigned WIDTH    = 8;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned LED_BITS = 4;
  localparam int unsigned DIV_BITS = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sample_loopback_gen_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LED_BITS(LED_BITS)) bus ();

  sample_loopback_gen #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LED_BITS(LED_BITS), .DIV_BITS(DIV_BITS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .lb_if  (bus)
  );

  typedef struct {
    logic [1:0] mode;
    logic [2:0] dly;
    logic [7:0] pdata;
    logic       pact;
    logic       sact;
    logic [7:0] exp_sd;
    logic       exp_pe;
  } vec_t;

  vec_t        tbl [16];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  hb_m  = '0;
  logic [31:0] lfsr_m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [2:0] d, input logic [7:0] pd,
                       input logic pa, input logic sa);
    bus.mode = m; bus.delay = d; bus.player_data = pd;
    bus.player_active = pa; bus.sampler_active = sa;
  endtask

  // One clock; outputs are examined 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    if (reset_n) hb_m = hb_m + 8'd1;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    hb_m = '0;
    step();
    step();
    chk("rst_sdata", 64'(bus.sampler_data), 64'd0);
    chk("rst_pe",    64'(bus.play_enable),  64'd0);
    chk("rst_err",   64'(bus.err_count),    64'd0);
    chk("rst_led",   64'(bus.led),          64'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    // mode, D, data, pact, sact, expected sampler_data, expected play_enable
    tbl[0]  = '{2'd0, 3'd3, 8'd1,  1'b1, 1'b0, 8'd0,  1'b0};
    tbl[1]  = '{2'd0, 3'd3, 8'd2,  1'b1, 1'b0, 8'd0,  1'b0};
    tbl[2]  = '{2'd0, 3'd3, 8'd3,  1'b1, 1'b0, 8'd0,  1'b0};
    tbl[3]  = '{2'd0, 3'd3, 8'd4,  1'b1, 1'b0, 8'd0,  1'b0};
    tbl[4]  = '{2'd0, 3'd3, 8'd5,  1'b1, 1'b0, 8'd1,  1'b0};
    tbl[5]  = '{2'd0, 3'd3, 8'd6,  1'b1, 1'b1, 8'd2,  1'b1};
    tbl[6]  = '{2'd0, 3'd3, 8'd7,  1'b1, 1'b0, 8'd3,  1'b0};
    tbl[7]  = '{2'd0, 3'd3, 8'd8,  1'b1, 1'b0, 8'd4,  1'b0};
    tbl[8]  = '{2'd0, 3'd3, 8'd9,  1'b1, 1'b0, 8'd5,  1'b0};
    tbl[9]  = '{2'd0, 3'd3, 8'd10, 1'b1, 1'b0, 8'd6,  1'b0};
    tbl[10] = '{2'd0, 3'd1, 8'd11, 1'b1, 1'b0, 8'd9,  1'b0};
    tbl[11] = '{2'd0, 3'd1, 8'd12, 1'b1, 1'b0, 8'd10, 1'b0};
    tbl[12] = '{2'd0, 3'd1, 8'd13, 1'b1, 1'b0, 8'd11, 1'b0};
    tbl[13] = '{2'd0, 3'd1, 8'd14, 1'b1, 1'b0, 8'd12, 1'b0};
    tbl[14] = '{2'd3, 3'd1, 8'd15, 1'b1, 1'b0, 8'd0,  1'b0};
    tbl[15] = '{2'd0, 3'd1, 8'd16, 1'b1, 1'b0, 8'd14, 1'b0};

    drive(2'd0, 3'd0, 8'd0, 1'b0, 1'b0);
    do_reset();

    // Loopback latency, delay change, mode change, play_enable pulse
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].mode, tbl[i].dly, tbl[i].pdata, tbl[i].pact, tbl[i].sact);
      step();
      chk($sformatf("tbl_sdata[%0d]", i), 64'(bus.sampler_data), 64'(tbl[i].exp_sd));
      chk($sformatf("tbl_pe[%0d]", i),    64'(bus.play_enable),  64'(tbl[i].exp_pe));
      chk($sformatf("tbl_led[%0d]", i),   64'(bus.led),          64'(hb_m[7:4]));
    end

    // Maximum delay across pointer wrap, then one inactive cycle
    drive(2'd0, 3'd0, 8'd0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      drive(2'd0, 3'd7, 8'(8'h10 + i), 1'b1, 1'b0);
      step();
      chk($sformatf("wrap_sdata[%0d]", i), 64'(bus.sampler_data),
          (i < 8) ? 64'd0 : 64'(8'h10 + i - 8));
    end
    drive(2'd0, 3'd7, 8'hEE, 1'b0, 1'b0);
    step();
    for (int j = 0; j < 10; j++) begin
      drive(2'd0, 3'd7, 8'(8'h40 + j), 1'b1, 1'b0);
      step();
      chk($sformatf("resume_sdata[%0d]", j), 64'(bus.sampler_data),
          (j < 8) ? 64'd0 : 64'(8'h40 + j - 8));
    end

    // Counter mode: wrap at 2^WIDTH, then hold
    drive(2'd0, 3'd0, 8'd0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 258; i++) begin
      drive(2'd1, 3'd0, 8'd0, 1'b0, 1'b1);
      step();
      chk($sformatf("cnt_sdata[%0d]", i), 64'(bus.sampler_data), 64'(i % 256));
    end
    chk("cnt_pe_on", 64'(bus.play_enable), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(2'd1, 3'd0, 8'd0, 1'b0, 1'b0);
      step();
      chk($sformatf("cnt_hold[%0d]", i), 64'(bus.sampler_data), 64'd2);
    end
    chk("cnt_pe_off", 64'(bus.play_enable), 64'd0);

    // Sequence checker: 5,6,8,9 gives one error
    drive(2'd1, 3'd0, 8'd5, 1'b1, 1'b0); step();
    drive(2'd1, 3'd0, 8'd6, 1'b1, 1'b0); step();
    chk("err_before_gap", 64'(bus.err_count), 64'd0);
    drive(2'd1, 3'd0, 8'd8, 1'b1, 1'b0); step();
    drive(2'd1, 3'd0, 8'd9, 1'b1, 1'b0); step();
    chk("err_one", 64'(bus.err_count), 64'd1);
    chk("err_led", 64'(bus.led), 64'({4{hb_m[3]}}));
    // First word after an inactive cycle and non-counter modes are ignored
    drive(2'd1, 3'd0, 8'd0,   1'b0, 1'b0); step();
    drive(2'd1, 3'd0, 8'd100, 1'b1, 1'b0); step();
    drive(2'd1, 3'd0, 8'd101, 1'b1, 1'b0); step();
    drive(2'd2, 3'd0, 8'd200, 1'b1, 1'b0); step();
    drive(2'd0, 3'd0, 8'd50,  1'b1, 1'b0); step();
    drive(2'd1, 3'd0, 8'd51,  1'b1, 1'b0); step();
    chk("err_ignored", 64'(bus.err_count), 64'd1);

    // Forced errors until saturation
    for (int i = 0; i < 70000; i++) begin
      drive(2'd1, 3'd0, 8'd0, 1'b1, 1'b0);
      step();
    end
    chk("err_sat", 64'(bus.err_count), 64'hFFFF);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("sat_led[%0d]", i), 64'(bus.led), 64'({4{hb_m[3]}}));
    end
    chk("err_sat_hold", 64'(bus.err_count), 64'hFFFF);

    // Mid-stream reset clears everything immediately
    drive(2'd2, 3'd0, 8'd0, 1'b1, 1'b1);
    step();
    step();
    reset_n = 1'b0;
    #1;
    hb_m = '0;
    chk("mid_rst_sdata", 64'(bus.sampler_data), 64'd0);
    chk("mid_rst_pe",    64'(bus.play_enable),  64'd0);
    chk("mid_rst_err",   64'(bus.err_count),    64'd0);
    chk("mid_rst_led",   64'(bus.led),          64'd0);
    step();
    reset_n = 1'b1;
    #1;
    chk("post_rst_sdata", 64'(bus.sampler_data), 64'd0);

    // LFSR against reference model
    lfsr_m = 32'h0000_0001;
    for (int i = 0; i < 1000; i++) begin
      drive(2'd2, 3'd0, 8'd0, 1'b0, 1'b1);
      step();
      chk($sformatf("lfsr[%0d]", i), 64'(bus.sampler_data), 64'(lfsr_m[7:0]));
      lfsr_m = {lfsr_m[30:0], lfsr_m[31] ^ lfsr_m[21] ^ lfsr_m[1] ^ lfsr_m[0]};
    end

    // Constant zero mode
    drive(2'd3, 3'd0, 8'd0, 1'b0, 1'b1);
    step();
    chk("zero_mode", 64'(bus.sampler_data), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sample_loopback_gen.md
SAMPLE_LOOPBACK_GEN -- requirements
Module: sample_loopback_gen

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, sample word width (8..64).
REQ-002 SHALL provide parameter DEPTH, default 16, delay-line entries (power of 2, 2..256).
REQ-003 SHALL provide parameter LED_BITS, default 4, number of LED outputs.
REQ-004 SHALL provide parameter DIV_BITS, default 24, heartbeat prescale exponent.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  sole clock, rising edge; reset_n  input  1  async active-low reset.
REQ-006 mode  input  2  source select: 0 loopback, 1 counter, 2 LFSR, 3 constant zero.
REQ-007 delay  input  log2(DEPTH)  loopback delay D, 0..DEPTH-1.
REQ-008 player_data  input  WIDTH  word played out by HPS each cycle.
REQ-009 player_active  input  1  player running (player reset deasserted).
REQ-010 sampler_active  input  1  sampler running (sampler reset deasserted).
REQ-011 sampler_data  output  WIDTH  word sampled by HPS each cycle, registered.
REQ-012 play_enable  output  1  enable to player, registered.
REQ-013 err_count  output  16  counter-mode sequence errors, saturating.
REQ-014 led  output  LED_BITS  heartbeat / error indicator.

Function
REQ-015 play_enable SHALL equal sampler_active delayed by exactly one clk.
REQ-016 Delay line SHALL be a DEPTH-entry circular buffer; while player_active=1 it writes player_data at wptr each cycle and wptr increments, wrapping DEPTH-1 -> 0.
REQ-017 Fill count SHALL increment per write, saturate at DEPTH, and clear to 0 on any cycle with player_active=0; wptr holds while player_active=0.
REQ-018 Mode 0: sampler_data at cycle t SHALL equal player_data written at cycle t-1-D when fill >= D+1, else 0; latency D+1 cycles.
REQ-019 Delay changes SHALL take effect the following cycle without clearing fill or buffer contents.
REQ-020 Mode 1: internal count SHALL increment by 1 each cycle sampler_active=1, wrap 2^WIDTH-1 -> 0, hold otherwise; sampler_data = count (registered).
REQ-021 Mode 2: 32-bit Fibonacci LFSR, taps 32,22,2,1, seed 0x00000001, SHALL step each cycle sampler_active=1; sampler_data = LFSR zero-extended or truncated to WIDTH.
REQ-022 Mode 3: sampler_data SHALL be 0.
REQ-023 Counter and LFSR state SHALL advance regardless of selected mode; mode change takes effect next cycle, no state reset.
REQ-024 Checker: in mode 1 with player_active=1 on two consecutive cycles, if player_data != previous player_data + 1 (mod 2^WIDTH), err_count SHALL increment, saturating at 0xFFFF.
REQ-025 Checker SHALL ignore the first player_active cycle after any inactive cycle and all cycles in modes 0, 2, 3.
REQ-026 Heartbeat counter of DIV_BITS+LED_BITS bits SHALL free-run, wrapping.
REQ-027 led SHALL equal heartbeat upper LED_BITS bits when err_count=0; otherwise all bits SHALL equal heartbeat[DIV_BITS-1].

Reset
REQ-028 On reset_n=0, asynchronously: sampler_data=0, play_enable=0, err_count=0, led=0, wptr=0, fill=0, count=0, heartbeat=0, LFSR=0x00000001.
REQ-029 Buffer contents SHALL NOT require reset; fill=0 guarantees no stale data is emitted.
REQ-030 Reset asserted mid-operation SHALL abort all activity; first post-release output is 0 in every mode.

Verification
REQ-031 Mode 0, D=3, player_active=1, player_data=1,2,3,... from cycle 0 -> sampler_data 0 through cycle 3, then 1,2,3,... from cycle 4.
REQ-032 Mode 0, D=DEPTH-1, 2*DEPTH writes -> correct values across wptr wrap; player_active dropped one cycle -> output 0 for D+1 cycles after resume.
REQ-033 Mode 1, WIDTH=8, sampler_active=1 for 258 cycles -> sampler_data 0..255, 0, 1; sampler_active=0 -> value holds.
REQ-034 Mode 1, player_data 5,6,8,9 with player_active=1 -> err_count=1; 70000 forced errors -> err_count=0xFFFF; led toggles together.
REQ-035 Mode 2 after reset -> first outputs 0x00000001 then LFSR sequence matching reference model for 1000 cycles.
REQ-036 sampler_active pulse 0->1->0 -> play_enable follows one cycle later; reset_n pulsed mid-stream -> all outputs 0 immediately.
